weight_fetch_ctrl: RTL and testbench
====================================

# weight_fetch_ctrl

Job-level read sequencer for the 32-bit weight SRAM in the multi-resolution inference datapath. Per job it walks a contiguous region organised as 32-word groups and reads only the first `budget+1` words of each group, the most-significant bit-planes at the requested resolution. Words are delivered downstream over a valid/ready stream with full backpressure support. It sits between the layer scheduler (config/start/done) and the PE array weight input.

## Interface
- `SRAM_DEPTH`, default 262144: SRAM words.
- `SRAM_ADDR_W`, default 18: address width, equal to log2(SRAM_DEPTH).
- `GRP_CNT_W`, default 13: width of the group count.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous reset, active-high.
- `cfg_start` input, 1 bit: starts a job. Sampled only in IDLE.
- `cfg_base_addr` input, SRAM_ADDR_W bits: address of word 0 of group 0.
- `cfg_num_groups` input, GRP_CNT_W bits: number of 32-word groups.
- `cfg_budget` input, 5 bits: words per group minus 1, range 0..31.
- `busy` output, 1 bit: job in progress.
- `done` output, 1 bit: one-cycle pulse at job completion.
- `sram_en` output, 1 bit: SRAM read strobe.
- `sram_addr` output, SRAM_ADDR_W bits: SRAM read address.
- `sram_data` input, 32 bits: read data, valid exactly 1 cycle after `sram_en`.
- `out_valid` output, 1 bit: stream valid.
- `out_ready` input, 1 bit: stream ready.
- `out_data` output, 32 bits: weight word.
- `out_last_grp` output, 1 bit: beat is the last word of its group.
- `out_last` output, 1 bit: beat is the last word of the job.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- **IDLE**
  - On `cfg_start`, latch base, num_groups and budget.
  - Clear the group counter g and the word counter k.
  - If num_groups==0, go to DONE. Otherwise go to FETCH.
- **FETCH** issues one read per cycle when credit allows.
  - Read address is base + 32·g + k, computed modulo 2^SRAM_ADDR_W, so the region may wrap past the top of the SRAM.
  - After each issue: if k==budget, set k=0 and g=g+1; otherwise k=k+1.
  - After issuing word (num_groups-1, budget), go to DRAIN.
- **DRAIN** waits until the final beat is accepted: `out_valid & out_ready & out_last`. Then go to DONE.
- **DONE** lasts 1 cycle with `done`=1, then returns to IDLE.
- Latched configuration is frozen for the whole job. `cfg_*` changes during a job have no effect.
- `cfg_start` is ignored in every state except IDLE.
- **Output buffer** is a 2-entry FIFO fed by returning SRAM data. Sideband flags travel with each word through a 1-cycle delay pipe.
- **Credit rule:** issue is allowed when (fifo_count + inflight − pop) < 2.
  - inflight is 0 or 1.
  - pop is `out_valid & out_ready` in the current cycle.
  - This rule guarantees the FIFO never overflows and never drops a word.
- `out_data`, `out_last_grp` and `out_last` are held stable while `out_valid & ~out_ready`.
- **Reset values:**
  - `busy`=0, `done`=0, `sram_en`=0, `sram_addr`=0.
  - `out_valid`=0, `out_data`=0, `out_last_grp`=0, `out_last`=0.
  - FIFO empty, FSM in IDLE.
- **Reset mid-job:** reset takes effect on the next edge. The in-flight read is discarded and no `done` is produced.

## Timing
- With `cfg_start` sampled at edge 0:
  - Edge 1: `busy`=1 and the first `sram_en`/`sram_addr` appear.
  - Edge 2: the first beat appears with `out_valid`=1.
- With `out_ready` held at 1, throughput is 1 beat per cycle with no bubbles. A job of N=num_groups·(budget+1) beats has its last beat at edge N+1.
- `done` is high during the cycle after the last handshake. `busy` is low in that same cycle, and the block accepts `cfg_start` in the cycle after `done`.
- num_groups==0: `busy`=1 and `done`=1 together during cycle 1, with no `sram_en`.
- `sram_en` is deasserted whenever no read is issued. `sram_addr` holds its last value when idle.
- When `out_ready` falls, at most 2 words are buffered and issue stalls. When `out_ready` rises, issue resumes in the same cycle.

## Test plan
- **Minimum budget:** base=0x00100, groups=2, budget=0, ready=1.
  - Required: reads at 0x00100 and 0x00120.
  - Required: 2 beats, both with `out_last_grp`=1; the second has `out_last`=1.
  - Required: `done` at cycle 4.
- **Full throughput:** base=0, groups=2, budget=31, ready=1.
  - Required: 64 consecutive reads, addresses 0..63.
  - Required: beats on cycles 2..65 with no gaps, `out_last_grp` on beats 32 and 64, `done` at cycle 66.
- **Backpressure:** groups=3, budget=4, `out_ready` driven with a pseudo-random 50% pattern.
  - Required: 15 beats in address order with none dropped or duplicated.
  - Required: data stable while stalled, and the FIFO never exceeds 2 entries.
- **Address wrap:** base=0x3FFE0, groups=2, budget=1.
  - Required: reads at 0x3FFE0, 0x3FFE1, 0x00000, 0x00001.
- **Empty job and start while busy:** groups=0 → `done` pulse at cycle 1 with no reads. Then pulse `cfg_start` with new config mid-job → ignored, and the original job completes unchanged.
- **Reset mid-job:** assert `reset` at beat 5 of a 32-beat job.
  - Required: all outputs at reset values on the next edge, and no `done`.
  - Required: a subsequent job runs correctly from g=0, k=0.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// Job-level weight SRAM read sequencer: reads the first budget+1 words of each 32-word group
// and streams them out through a 2-entry credit-controlled buffer with full backpressure.
module weight_fetch_ctrl #(
  parameter int unsigned SRAM_DEPTH  = 262144,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned GRP_CNT_W   = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [SRAM_ADDR_W-1:0] cfg_base_addr,
  input  logic [GRP_CNT_W-1:0]   cfg_num_groups,
  input  logic [4:0]             cfg_budget,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_en,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [31:0]            sram_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last_grp,
  output logic                   out_last
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [GRP_CNT_W-1:0]   ngrp_q, ngrp_d;
  logic [4:0]             budget_q, budget_d;
  logic [GRP_CNT_W-1:0]   g_q, g_d;
  logic [4:0]             k_q, k_d;
  logic [SRAM_ADDR_W-1:0] last_addr_q;

  logic                   inflight_q;
  logic                   pipe_grp_q, pipe_last_q;

  logic [31:0]            mem_data_q [2];
  logic                   mem_grp_q  [2];
  logic                   mem_last_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;

  logic                   pop, push, fifo_pop, issue;
  logic                   last_k, last_g;
  logic [2:0]             occ;
  logic [GRP_CNT_W+4:0]   g_off;
  logic [31:0]            sum32;
  logic [SRAM_ADDR_W-1:0] cur_addr;

  // Address arithmetic is done wide and wrapped at the SRAM size.
  assign g_off    = {g_q, 5'd0};
  assign sum32    = 32'(base_q) + 32'(g_off) + 32'(k_q);
  assign cur_addr = SRAM_ADDR_W'(sum32 & (SRAM_DEPTH - 1));

  assign last_k   = (k_q == budget_q);
  assign last_g   = (g_q == ngrp_q - GRP_CNT_W'(1));

  assign out_valid = (count_q != 2'd0) | inflight_q;
  assign pop       = out_valid & out_ready;
  // Words already buffered or on their way back, minus the one leaving this cycle.
  assign occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == StFetch) && (occ < 3'd2);

  assign sram_en   = issue;
  assign sram_addr = issue ? cur_addr : last_addr_q;

  // A returning word bypasses the buffer when it is empty and the word is taken at once.
  assign push      = inflight_q & ~(pop & (count_q == 2'd0));
  assign fifo_pop  = pop & (count_q != 2'd0);

  always_comb begin
    out_data     = '0;
    out_last_grp = 1'b0;
    out_last     = 1'b0;
    if (count_q != 2'd0) begin
      out_data     = mem_data_q[rd_ptr_q];
      out_last_grp = mem_grp_q[rd_ptr_q];
      out_last     = mem_last_q[rd_ptr_q];
    end else if (inflight_q) begin
      out_data     = sram_data;
      out_last_grp = pipe_grp_q;
      out_last     = pipe_last_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    ngrp_d   = ngrp_q;
    budget_d = budget_q;
    g_d      = g_q;
    k_d      = k_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          base_d   = cfg_base_addr;
          ngrp_d   = cfg_num_groups;
          budget_d = cfg_budget;
          g_d      = '0;
          k_d      = '0;
          state_d  = (cfg_num_groups == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (issue) begin
          if (last_k) begin
            k_d = '0;
            g_d = g_q + GRP_CNT_W'(1);
            if (last_g) state_d = StDrain;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign done = (state_q == StDone);
  // An empty job reports busy alongside its done pulse; a normal job has already dropped busy.
  assign busy = (state_q == StFetch) || (state_q == StDrain) ||
                ((state_q == StDone) && (ngrp_q == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      ngrp_q      <= '0;
      budget_q    <= '0;
      g_q         <= '0;
      k_q         <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      pipe_grp_q  <= 1'b0;
      pipe_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      ngrp_q     <= ngrp_d;
      budget_q   <= budget_d;
      g_q        <= g_d;
      k_q        <= k_d;
      inflight_q <= issue;
      if (issue) begin
        last_addr_q <= cur_addr;
        pipe_grp_q  <= last_k;
        pipe_last_q <= last_k & last_g;
      end
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= sram_data;
      mem_grp_q[wr_ptr_q]  <= pipe_grp_q;
      mem_last_q[wr_ptr_q] <= pipe_last_q;
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: behavioural SRAM, per-scenario tasks with inline checks.
module tb_weight_fetch_ctrl;
  localparam int AW = 18;
  localparam int GW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr;
  logic [GW-1:0] cfg_num_groups;
  logic [4:0]    cfg_budget;
  logic          busy, done, sram_en;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_data;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic          out_last_grp, out_last;

  weight_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_groups (cfg_num_groups),
    .cfg_budget     (cfg_budget),
    .busy           (busy),
    .done           (done),
    .sram_en        (sram_en),
    .sram_addr      (sram_addr),
    .sram_data      (sram_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last_grp   (out_last_grp),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [AW-1:0] a);
    return 32'hA500_0000 | {14'd0, a};
  endfunction

  // Synchronous SRAM: data for an enabled read shows up the following cycle.
  always @(posedge clk) sram_data <= sram_en ? mk(sram_addr) : 32'hDEAD_BEEF;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] rd_q[$];
  int            rd_cyc_q[$];
  logic [31:0]   bt_data_q[$];
  logic          bt_grp_q[$];
  logic          bt_last_q[$];
  int            bt_cyc_q[$];
  int            done_cyc, n_done, stall_bad, occ_max;
  logic          busy1;

  task automatic run_job(input logic [AW-1:0] base, input int ngrp, input int bud,
                         input bit rnd, input int inj_cyc, input int max_cyc);
    logic [15:0] lfsr = 16'hACE1;
    bit          pv = 0, pr = 0;
    logic [33:0] pd = '0;
    int          issued = 0, acc = 0;
    rd_q.delete(); rd_cyc_q.delete(); bt_data_q.delete(); bt_grp_q.delete();
    bt_last_q.delete(); bt_cyc_q.delete();
    done_cyc = -1; n_done = 0; stall_bad = 0; occ_max = 0; busy1 = 1'bx;
    @(negedge clk);
    cfg_base_addr = base; cfg_num_groups = GW'(ngrp); cfg_budget = 5'(bud);
    cfg_start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      cfg_start = (c == inj_cyc);
      if (c == inj_cyc) begin
        cfg_base_addr = base ^ 18'h15555; cfg_num_groups = GW'(ngrp + 3); cfg_budget = 5'(bud + 2);
      end
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        out_ready = lfsr[0];
      end else out_ready = 1'b1;
      #1;
      if (c == 1) busy1 = busy;
      if (issued - acc > occ_max) occ_max = issued - acc;
      if (pv && !pr && (!out_valid || {out_data, out_last_grp, out_last} !== pd)) stall_bad++;
      pv = out_valid; pr = out_ready; pd = {out_data, out_last_grp, out_last};
      if (sram_en) begin rd_q.push_back(sram_addr); rd_cyc_q.push_back(c); issued++; end
      if (out_valid && out_ready) begin
        bt_data_q.push_back(out_data); bt_grp_q.push_back(out_last_grp);
        bt_last_q.push_back(out_last); bt_cyc_q.push_back(c); acc++;
      end
      if (done) begin n_done++; done_cyc = c; break; end
    end
    if (n_done == 0) $display("FAIL job_timeout: no done within %0d cycles", max_cyc);
    cfg_start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_start = 1'b0; out_ready = 1'b1;
    cfg_base_addr = '0; cfg_num_groups = '0; cfg_budget = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({busy, done, sram_en} !== 3'b000) begin fails++;
      $display("FAIL reset_ctrl: got %b want 000", {busy, done, sram_en}); end
    tests++; if (sram_addr !== '0) begin fails++;
      $display("FAIL reset_addr: got %h want 0", sram_addr); end
    tests++; if ({out_valid, out_last_grp, out_last} !== 3'b000 || out_data !== 32'd0) begin
      fails++; $display("FAIL reset_out: got v%b d%h want all zero", out_valid, out_data); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_min_budget();
    run_job(18'h00100, 2, 0, 0, 0, 50);
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL min_busy: got %b want 1", busy1); end
    tests++; if (rd_q.size() != 2) begin fails++;
      $display("FAIL min_reads: got %0d want 2", rd_q.size()); end
    else begin
      tests++; if (rd_q[0] !== 18'h00100 || rd_q[1] !== 18'h00120) begin fails++;
        $display("FAIL min_addr: got %h %h want 00100 00120", rd_q[0], rd_q[1]); end
    end
    tests++; if (bt_data_q.size() != 2) begin fails++;
      $display("FAIL min_beats: got %0d want 2", bt_data_q.size()); end
    else begin
      tests++; if ({bt_grp_q[0], bt_last_q[0], bt_grp_q[1], bt_last_q[1]} !== 4'b1011) begin
        fails++; $display("FAIL min_flags: got %b want 1011",
                          {bt_grp_q[0], bt_last_q[0], bt_grp_q[1], bt_last_q[1]}); end
      tests++; if (bt_data_q[1] !== mk(18'h00120)) begin fails++;
        $display("FAIL min_data: got %h want %h", bt_data_q[1], mk(18'h00120)); end
    end
    tests++; if (done_cyc != 4) begin fails++; $display("FAIL min_done: got %0d want 4", done_cyc); end
  endtask

  task automatic test_full_throughput();
    int bad = 0;
    run_job(18'h0, 2, 31, 0, 0, 120);
    tests++; if (rd_q.size() != 64 || bt_data_q.size() != 64) begin fails++;
      $display("FAIL full_count: got %0d reads %0d beats want 64", rd_q.size(), bt_data_q.size()); end
    else begin
      for (int i = 0; i < 64; i++) begin
        if (rd_q[i] !== AW'(i) || rd_cyc_q[i] != i + 1 || bt_cyc_q[i] != i + 2 ||
            bt_data_q[i] !== mk(AW'(i)) || bt_grp_q[i] !== (i == 31 || i == 63) ||
            bt_last_q[i] !== (i == 63)) bad++;
      end
      tests++; if (bad != 0) begin fails++;
        $display("FAIL full_stream: got %0d bad beats want 0", bad); end
    end
    tests++; if (done_cyc != 66) begin fails++; $display("FAIL full_done: got %0d want 66", done_cyc); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    logic [AW-1:0] a;
    run_job(18'h02000, 3, 4, 1, 0, 400);
    tests++; if (n_done != 1) begin fails++; $display("FAIL bp_done: got %0d want 1", n_done); end
    tests++; if (bt_data_q.size() != 15 || rd_q.size() != 15) begin fails++;
      $display("FAIL bp_count: got %0d beats %0d reads want 15", bt_data_q.size(), rd_q.size()); end
    else begin
      for (int i = 0; i < 15; i++) begin
        a = AW'(18'h02000 + 32 * (i / 5) + (i % 5));
        if (rd_q[i] !== a || bt_data_q[i] !== mk(a) || bt_grp_q[i] !== (i % 5 == 4) ||
            bt_last_q[i] !== (i == 14)) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL bp_order: got %0d bad beats want 0", bad); end
    end
    tests++; if (stall_bad != 0) begin fails++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
    tests++; if (occ_max > 2 || occ_max < 1) begin fails++;
      $display("FAIL bp_occupancy: got %0d want 1..2", occ_max); end
  endtask

  task automatic test_wrap();
    run_job(18'h3FFE0, 2, 1, 0, 0, 50);
    tests++; if (rd_q.size() != 4) begin fails++; $display("FAIL wrap_reads: got %0d want 4", rd_q.size()); end
    else begin
      tests++; if ({rd_q[0], rd_q[1], rd_q[2], rd_q[3]} !== {18'h3FFE0, 18'h3FFE1, 18'h0, 18'h1}) begin
        fails++; $display("FAIL wrap_addr: got %h %h %h %h want 3ffe0 3ffe1 0 1",
                          rd_q[0], rd_q[1], rd_q[2], rd_q[3]); end
    end
    tests++; if (done_cyc != 6) begin fails++; $display("FAIL wrap_done: got %0d want 6", done_cyc); end
  endtask

  task automatic test_empty_and_start_busy();
    run_job(18'h00123, 0, 5, 0, 0, 10);
    tests++; if (done_cyc != 1 || busy1 !== 1'b1) begin fails++;
      $display("FAIL empty_done: got cycle %0d busy %b want 1 1", done_cyc, busy1); end
    tests++; if (rd_q.size() != 0 || bt_data_q.size() != 0) begin fails++;
      $display("FAIL empty_reads: got %0d reads %0d beats want 0", rd_q.size(), bt_data_q.size()); end
    run_job(18'h00400, 2, 3, 0, 3, 60);
    tests++; if (rd_q.size() != 8) begin fails++;
      $display("FAIL busy_start_reads: got %0d want 8", rd_q.size()); end
    else begin
      tests++; if (rd_q[3] !== 18'h00403 || rd_q[4] !== 18'h00420 || rd_q[7] !== 18'h00423) begin
        fails++; $display("FAIL busy_start_addr: got %h %h %h want 00403 00420 00423",
                          rd_q[3], rd_q[4], rd_q[7]); end
    end
    tests++; if (done_cyc != 10) begin fails++;
      $display("FAIL busy_start_done: got %0d want 10", done_cyc); end
  endtask

  task automatic test_reset_mid_job();
    int spurious = 0;
    @(negedge clk);
    cfg_base_addr = 18'h00800; cfg_num_groups = GW'(1); cfg_budget = 5'd31;
    cfg_start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); cfg_start = 1'b0;
    end
    #1;
    tests++; if (out_valid !== 1'b1 || out_data !== mk(18'h00804)) begin fails++;
      $display("FAIL mid_beat5: got v%b d%h want v1 d%h", out_valid, out_data, mk(18'h00804)); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if ({busy, done, sram_en, out_valid, out_last_grp, out_last} !== 6'b0 ||
                 sram_addr !== '0 || out_data !== 32'd0) begin fails++;
      $display("FAIL mid_reset_outs: got %b addr %h data %h want zeros",
               {busy, done, sram_en, out_valid, out_last_grp, out_last}, sram_addr, out_data); end
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (done || sram_en || out_valid) spurious++;
    end
    tests++; if (spurious != 0) begin fails++;
      $display("FAIL mid_no_done: got %0d active cycles want 0", spurious); end
    run_job(18'h00800, 1, 3, 0, 0, 40);
    tests++; if (rd_q.size() != 4 || bt_data_q.size() != 4) begin fails++;
      $display("FAIL mid_rerun_count: got %0d reads %0d beats want 4", rd_q.size(), bt_data_q.size()); end
    else begin
      tests++; if (rd_q[0] !== 18'h00800 || rd_q[3] !== 18'h00803 ||
                   bt_data_q[0] !== mk(18'h00800) || bt_last_q[3] !== 1'b1) begin fails++;
        $display("FAIL mid_rerun_data: got %h %h %h %b want 00800 00803 %h 1",
                 rd_q[0], rd_q[3], bt_data_q[0], bt_last_q[3], mk(18'h00800)); end
    end
    tests++; if (done_cyc != 6) begin fails++; $display("FAIL mid_rerun_done: got %0d want 6", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_min_budget();
    test_full_throughput();
    test_backpressure();
    test_wrap();
    test_empty_and_start_busy();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
